// File: rtl/mac_row_seq.sv
// Load/execute/drain sequencer feeding the west edge of one systolic MAC row.
// Optional MAC_ROW_SEQ_PERF_EN adds a saturating stall_cnt output.
module mac_row_seq #(
  parameter int unsigned bw     = 4,
  parameter int unsigned col    = 8,
  parameter int unsigned len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_2b,
  input  logic [len_bw-1:0] act_len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [bw-1:0]     in_data,
  output logic [bw-1:0]     out_w,
  output logic [1:0]        out_inst,
  output logic              cfg_2b,
  output logic              busy,
  output logic              done
`ifdef MAC_ROW_SEQ_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(col) + 1;
  localparam logic [CntW-1:0] ColCnt  = CntW'(col);
  localparam logic [CntW-1:0] ColLast = CntW'(col - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [CntW-1:0]     dr_cnt_q, dr_cnt_d;
  logic [len_bw-1:0]   act_cnt_q, act_cnt_d;
  logic [len_bw-1:0]   act_rem_q, act_rem_d;
  logic [bw-1:0]       out_w_q, out_w_d;
  logic [1:0]          out_inst_q, out_inst_d;
  logic                cfg_q, cfg_d;
  logic                done_q, done_d;
  logic                beat;
  logic [CntW-1:0]     ld_inc;
  logic [len_bw-1:0]   act_inc;

  assign in_ready = ((state_q == StLoad) || (state_q == StExec)) && !abort;
  assign beat     = in_valid && in_ready;
  assign ld_inc   = ld_cnt_q + CntW'(1);
  assign act_inc  = act_cnt_q + len_bw'(1);

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    dr_cnt_d   = dr_cnt_q;
    act_cnt_d  = act_cnt_q;
    act_rem_d  = act_rem_q;
    out_w_d    = out_w_q;
    out_inst_d = 2'b00;
    cfg_d      = cfg_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          cfg_d     = mode_2b;
          act_rem_d = act_len;
          ld_cnt_d  = '0;
          act_cnt_d = '0;
          dr_cnt_d  = '0;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d  = StDrain;
          dr_cnt_d = '0;
        end else if (beat) begin
          out_w_d    = in_data;
          out_inst_d = 2'b01;
          ld_cnt_d   = ld_inc;
          if (ld_inc == ColCnt) begin
            state_d  = (act_rem_q != '0) ? StExec : StDrain;
            dr_cnt_d = '0;
          end
        end
      end
      StExec: begin
        if (abort) begin
          state_d  = StDrain;
          dr_cnt_d = '0;
        end else if (beat) begin
          out_w_d    = in_data;
          out_inst_d = 2'b10;
          act_cnt_d  = act_inc;
          if (act_inc == act_rem_q) begin
            state_d  = StDrain;
            dr_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        // Zeros flush the row's instruction chain so its valid falls.
        out_w_d  = '0;
        dr_cnt_d = dr_cnt_q + CntW'(1);
        if (dr_cnt_q == ColLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ld_cnt_q   <= '0;
      dr_cnt_q   <= '0;
      act_cnt_q  <= '0;
      act_rem_q  <= '0;
      out_w_q    <= '0;
      out_inst_q <= 2'b00;
      cfg_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      dr_cnt_q   <= dr_cnt_d;
      act_cnt_q  <= act_cnt_d;
      act_rem_q  <= act_rem_d;
      out_w_q    <= out_w_d;
      out_inst_q <= out_inst_d;
      cfg_q      <= cfg_d;
      done_q     <= done_d;
    end
  end

  assign out_w    = out_w_q;
  assign out_inst = out_inst_q;
  assign cfg_2b   = cfg_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);

`ifdef MAC_ROW_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && start) begin
      stall_d = '0;
    end else if (((state_q == StLoad) || (state_q == StExec)) && !in_valid &&
                 (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_row_seq.sv
// Directed, table-driven bench for mac_row_seq: each record is one clock cycle
// of inputs plus the outputs expected during that same cycle.
module tb_mac_row_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mode_2b;
  logic [7:0] act_len;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] out_w;
  logic [1:0] out_inst;
  logic       cfg_2b;
  logic       busy;
  logic       done;
`ifdef MAC_ROW_SEQ_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int failures;

  mac_row_seq #(.bw(4), .col(8), .len_bw(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode_2b  (mode_2b),
    .act_len  (act_len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_w    (out_w),
    .out_inst (out_inst),
    .cfg_2b   (cfg_2b),
    .busy     (busy),
    .done     (done)
`ifdef MAC_ROW_SEQ_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       md;
    logic [7:0] al;
    logic       v;
    logic [3:0] d;
    logic       ab;
    logic [1:0] e_inst;
    logic [3:0] e_w;
    logic       e_busy;
    logic       e_done;
    logic       e_cfg;
    logic       e_rdy;
  } vec_t;

  vec_t vq[$];

  function automatic void push(input logic st, input logic md, input int al, input logic v,
                               input int d, input logic ab, input logic [1:0] e_inst,
                               input int e_w, input logic e_busy, input logic e_done,
                               input logic e_cfg, input logic e_rdy);
    vec_t r;
    r.st = st; r.md = md; r.al = 8'(al); r.v = v; r.d = 4'(d); r.ab = ab;
    r.e_inst = e_inst; r.e_w = 4'(e_w); r.e_busy = e_busy; r.e_done = e_done;
    r.e_cfg = e_cfg; r.e_rdy = e_rdy;
    vq.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; mode_2b = 0; act_len = 0; abort = 0; in_valid = 0; in_data = 0;
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the following cycle.
  task automatic run_vecs(input string nm);
    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].st; mode_2b = vq[i].md; act_len = vq[i].al;
      in_valid = vq[i].v; in_data = vq[i].d; abort = vq[i].ab;
      #1;
      chk($sformatf("%s[%0d].inst", nm, i), 32'(out_inst), 32'(vq[i].e_inst));
      chk($sformatf("%s[%0d].w", nm, i), 32'(out_w), 32'(vq[i].e_w));
      chk($sformatf("%s[%0d].busy", nm, i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("%s[%0d].done", nm, i), 32'(done), 32'(vq[i].e_done));
      chk($sformatf("%s[%0d].cfg", nm, i), 32'(cfg_2b), 32'(vq[i].e_cfg));
      chk($sformatf("%s[%0d].rdy", nm, i), 32'(in_ready), 32'(vq[i].e_rdy));
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  // act_len=4, mode=1, weights 1..8 then activations 9..12, no bubbles.
  task automatic build_nominal();
    vq.delete();
    push(1, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      push(0, 0, 0, 1, k, 0, (k == 1) ? 2'b00 : 2'b01, k - 1, 1, 0, 1, 1);
    for (int k = 9; k <= 12; k++)
      push(0, 0, 0, 1, k, 0, (k == 9) ? 2'b01 : 2'b10, k - 1, 1, 0, 1, 1);
    for (int k = 13; k <= 20; k++)
      push(0, 0, 0, 0, 0, 0, (k == 13) ? 2'b10 : 2'b00, (k == 13) ? 12 : 0, 1, 0, 1, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
  endtask

  // Bubble on every odd cycle, beat n on cycle 2n; junk data on bubbles.
  task automatic build_bubbles();
    vq.delete();
    push(1, 0, 4, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 24; k++) begin
      logic [1:0] ei;
      if (k == 1) ei = 2'b00;
      else if (((k - 1) % 2) == 0) ei = (((k - 1) / 2) <= 8) ? 2'b01 : 2'b10;
      else ei = 2'b00;
      push(0, 0, 0, (k % 2) == 0, ((k % 2) == 0) ? k / 2 : 15, 0, ei, (k - 1) / 2,
           1, 0, 0, 1);
    end
    for (int k = 25; k <= 32; k++)
      push(0, 0, 0, 0, 0, 0, (k == 25) ? 2'b10 : 2'b00, (k == 25) ? 12 : 0, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // act_len=0: weights 4..11, then straight to drain; valid held high in drain.
  task automatic build_len0();
    vq.delete();
    push(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      push(0, 0, 0, 1, k + 3, 0, (k == 1) ? 2'b00 : 2'b01, (k == 1) ? 0 : k + 2, 1, 0, 1, 1);
    for (int k = 9; k <= 16; k++)
      push(0, 0, 0, 1, 15, 0, (k == 9) ? 2'b01 : 2'b00, (k == 9) ? 11 : 0, 1, 0, 1, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
  endtask

  // act_len=6; abort on the 3rd EXEC beat (cycle 11) with valid high; a
  // second abort during drain must be ignored.
  task automatic build_abort();
    vq.delete();
    push(1, 0, 6, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++)
      push(0, 0, 0, 1, k, 0, (k == 1) ? 2'b00 : 2'b01, k - 1, 1, 0, 0, 1);
    push(0, 0, 0, 1, 9, 0, 2'b01, 8, 1, 0, 0, 1);
    push(0, 0, 0, 1, 10, 0, 2'b10, 9, 1, 0, 0, 1);
    push(0, 0, 0, 1, 11, 1, 2'b10, 10, 1, 0, 0, 0);
    push(0, 0, 0, 1, 13, 0, 2'b00, 10, 1, 0, 0, 0);
    for (int k = 13; k <= 19; k++)
      push(0, 0, 0, 1, 13, k == 15, 2'b00, 0, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // start held through done; mode input changes mid-job but cfg follows
  // only the accepted start. Second job is aborted at cycle 19.
  task automatic build_b2b();
    vq.delete();
    push(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      push(1, 0, 0, 1, k, 0, (k == 1) ? 2'b00 : 2'b01, k - 1, 1, 0, 1, 1);
    for (int k = 9; k <= 16; k++)
      push(1, 0, 0, 0, 0, 0, (k == 9) ? 2'b01 : 2'b00, (k == 9) ? 8 : 0, 1, 0, 1, 0);
    push(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1);
    push(0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0);
    for (int k = 20; k <= 27; k++)
      push(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    push(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ndone;
    checks = 0;
    failures = 0;
    idle_inputs();
    reset = 1;
    #2;
    chk("rst.inst", 32'(out_inst), 0);
    chk("rst.w", 32'(out_w), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.cfg", 32'(cfg_2b), 0);
    chk("rst.rdy", 32'(in_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;

    build_nominal();
    run_vecs("nominal");
`ifdef MAC_ROW_SEQ_PERF_EN
    chk("nominal.stall", 32'(stall_cnt), 0);
`endif
    build_bubbles();
    run_vecs("bubbles");
`ifdef MAC_ROW_SEQ_PERF_EN
    chk("bubbles.stall", 32'(stall_cnt), 12);
`endif
    build_len0();
    run_vecs("len0");
    build_abort();
    run_vecs("abort");
    build_b2b();
    run_vecs("b2b");

    // Async reset in the middle of EXEC.
    start = 1; mode_2b = 1; act_len = 4;
    @(posedge clk);
    #1;
    idle_inputs();
    in_valid = 1;
    for (int k = 1; k <= 10; k++) begin
      in_data = 4'(k);
      @(posedge clk);
      #1;
    end
    in_data = 4'd11;
    #1;
    chk("arst.pre_inst", 32'(out_inst), 32'(2'b10));
    chk("arst.pre_busy", 32'(busy), 1);
    #2 reset = 1;
    #1;
    chk("arst.inst", 32'(out_inst), 0);
    chk("arst.w", 32'(out_w), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.cfg", 32'(cfg_2b), 0);
    chk("arst.rdy", 32'(in_ready), 0);
`ifdef MAC_ROW_SEQ_PERF_EN
    chk("arst.stall", 32'(stall_cnt), 0);
`endif
    @(posedge clk);
    #3 reset = 0;
    @(posedge clk);
    #1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("arst.no_done", 32'(ndone), 0);
    chk("arst.idle_busy", 32'(busy), 0);
    idle_inputs();

    build_nominal();
    run_vecs("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
